// File: rtl/count_sequencer.sv
// Run/pause/lap sequencer for the seconds counter: turns button levels into one-cycle clear
// and increment strobes. Button events act on the edge that samples them; increments are TICKS_PER_SEC cycles apart.
module count_sequencer #(
   parameter int TICKS_PER_SEC = 100,
   parameter int MAX_COUNT     = 19,
   parameter int W             = 5
) (
   input  logic         clk,
   input  logic         reset_clean,
   input  logic         start_stop_btn,
   input  logic         clear_btn,
   input  logic         lap_btn,
   input  logic [W-1:0] count_in,
   output logic         inc_pulse,
   output logic         clr_pulse,
   output logic         wrap_pulse,
   output logic [W-1:0] disp_value,
   output logic         running,
   output logic         frozen,
   output logic [1:0]   state
);

   localparam int PW = $clog2(TICKS_PER_SEC);
   localparam logic [PW-1:0] PS_MAX    = PW'(TICKS_PER_SEC - 1);
   localparam logic [W-1:0]  CNT_MAX   = W'(MAX_COUNT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } state_t;

   state_t        cur_state, nxt_state;
   logic [PW-1:0] presc, presc_nxt;
   logic [W-1:0]  lap_value, lap_nxt, disp_nxt;
   logic          ss_q, clr_q, lap_q;
   logic          inc_nxt, clr_nxt, wrap_nxt;
   logic          clr_ev, ss_ev, lap_ev, advance;

   // Lower-priority events in the same cycle are dropped, not deferred.
   assign clr_ev = clear_btn & ~clr_q;
   assign ss_ev  = start_stop_btn & ~ss_q & ~clr_ev;
   assign lap_ev = lap_btn & ~lap_q & ~clr_ev & ~ss_ev;

   assign state   = cur_state;
   assign running = (cur_state == RUN) || (cur_state == LAP);
   assign frozen  = (cur_state == LAP);

   always_ff @(posedge clk or posedge reset_clean) begin
      if (reset_clean) begin
         cur_state  <= IDLE;
         presc      <= '0;
         lap_value  <= '0;
         ss_q       <= 1'b0;
         clr_q      <= 1'b0;
         lap_q      <= 1'b0;
         inc_pulse  <= 1'b0;
         clr_pulse  <= 1'b0;
         wrap_pulse <= 1'b0;
         disp_value <= '0;
      end else begin
         cur_state  <= nxt_state;
         presc      <= presc_nxt;
         lap_value  <= lap_nxt;
         ss_q       <= start_stop_btn;
         clr_q      <= clear_btn;
         lap_q      <= lap_btn;
         inc_pulse  <= inc_nxt;
         clr_pulse  <= clr_nxt;
         wrap_pulse <= wrap_nxt;
         disp_value <= disp_nxt;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      presc_nxt = presc;
      lap_nxt   = lap_value;
      inc_nxt   = 1'b0;
      clr_nxt   = 1'b0;
      wrap_nxt  = 1'b0;

      // Leaving RUN/LAP via start_stop freezes the phase so a resume continues the same second.
      advance = running && !clr_ev && !ss_ev;
      if (advance) begin
         if (presc == PS_MAX) begin
            presc_nxt = '0;
            inc_nxt   = 1'b1;
            wrap_nxt  = (count_in == CNT_MAX);
         end else begin
            presc_nxt = presc + 1'b1;
         end
      end

      if (clr_ev) begin
         nxt_state = IDLE;
         clr_nxt   = 1'b1;
         presc_nxt = '0;
         lap_nxt   = '0;
      end else begin
         case (cur_state)
            IDLE: begin
               if (ss_ev) begin
                  nxt_state = RUN;
                  presc_nxt = '0;
               end
            end
            RUN: begin
               if (ss_ev) begin
                  nxt_state = PAUSE;
               end else if (lap_ev) begin
                  nxt_state = LAP;
                  lap_nxt   = count_in;
               end
            end
            PAUSE: begin
               if (ss_ev) nxt_state = RUN;
            end
            LAP: begin
               if (ss_ev)       nxt_state = PAUSE;
               else if (lap_ev) nxt_state = RUN;
            end
            default: nxt_state = IDLE;
         endcase
      end

      disp_nxt = (nxt_state == LAP) ? lap_nxt : count_in;
   end

endmodule
